// File: rtl/amiga_clk_pkg.sv
`default_nettype none
// ============================================================================
// Package  : amiga_clk_pkg
// Brief    : shared state encoding, defaults and helpers for amiga_clken_gen
// Revision : 1.0
// ============================================================================
package amiga_clk_pkg;

    localparam logic [2:0] C_ST_IDLE      = 3'd0;
    localparam logic [2:0] C_ST_WAIT_LOCK = 3'd1;
    localparam logic [2:0] C_ST_STABLE    = 3'd2;
    localparam logic [2:0] C_ST_ALIGN     = 3'd3;
    localparam logic [2:0] C_ST_RUN       = 3'd4;

    typedef enum logic [2:0] {
        IDLE      = C_ST_IDLE,
        WAIT_LOCK = C_ST_WAIT_LOCK,
        STABLE    = C_ST_STABLE,
        ALIGN     = C_ST_ALIGN,
        RUN       = C_ST_RUN
    } clken_state_t;

    localparam int unsigned C_DEF_DIV = 3;

    function automatic int unsigned phase_clamp(input int unsigned phase, input int unsigned div);
        return (phase < div) ? phase : div;
    endfunction

endpackage
`default_nettype wire

// File: rtl/amiga_clken_chan.sv
`default_nettype none
// ============================================================================
// Module   : amiga_clken_chan
// Brief    : one phase-programmable clock-enable channel (down-counter + decode)
// Revision : 1.0
// ============================================================================
module amiga_clken_chan
    import amiga_clk_pkg::*;
#(
    parameter int unsigned DIV_W   = 8,
    parameter int unsigned DEF_DIV = C_DEF_DIV
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_run,
    input  logic             i_align,
    input  logic [DIV_W-1:0] i_pend_div,
    input  logic [DIV_W-1:0] i_pend_phase,
    input  logic [DIV_W-1:0] i_tc_div,
    output logic             o_ce,
    output logic             o_ce_ph
);

    localparam logic [DIV_W-1:0] C_ONE = DIV_W'(1);
    localparam logic [DIV_W-1:0] C_DEF = DIV_W'(DEF_DIV);

    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] w_half;
    logic             w_tc;

    assign w_tc    = (r_cnt == '0);
    assign w_half  = (r_div + C_ONE) >> 1;
    assign o_ce    = i_run & w_tc;
    assign o_ce_ph = i_run & ((r_div == '0) | (r_cnt == w_half));

    // The active divide only changes at terminal count, so no period is ever cut short.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_div <= C_DEF;
        end else if (i_align) begin
            r_cnt <= DIV_W'(phase_clamp(32'(i_pend_phase), 32'(i_pend_div)));
            r_div <= i_pend_div;
        end else if (i_run) begin
            if (w_tc) begin
                r_cnt <= i_tc_div;
                r_div <= i_tc_div;
            end else begin
                r_cnt <= r_cnt - C_ONE;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/amiga_clken_gen.sv
`default_nettype none
// ============================================================================
// Module   : amiga_clken_gen
// Brief    : lock-sequenced reset release and NUM_CH phased clock enables;
//            AMIGA_CLKEN_STATUS_EN adds the lock_loss_cnt status output
// Revision : 1.0
// ============================================================================
module amiga_clken_gen
    import amiga_clk_pkg::*;
#(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned DIV_W       = 8,
    parameter int unsigned LOCK_CYCLES = 1024,
    parameter int unsigned DEF_DIV     = C_DEF_DIV
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    pll_locked,
    input  logic [NUM_CH*DIV_W-1:0] div_cfg,
    input  logic [NUM_CH*DIV_W-1:0] phase_cfg,
    input  logic                    cfg_load,
    output logic [NUM_CH-1:0]       ce,
    output logic [NUM_CH-1:0]       ce_ph,
    output logic                    sys_rst,
`ifdef AMIGA_CLKEN_STATUS_EN
    output logic [7:0]              lock_loss_cnt,
`endif
    output logic                    running
);

    localparam int unsigned        C_LCW       = $clog2(LOCK_CYCLES);
    localparam logic [C_LCW-1:0]   C_LOCK_LAST = C_LCW'(LOCK_CYCLES - 1);
    localparam logic [C_LCW-1:0]   C_LOCK_ONE  = C_LCW'(1);

    clken_state_t              r_state;
    clken_state_t              w_state_nxt;
    logic [C_LCW-1:0]          r_lock_cnt;
    logic [C_LCW-1:0]          w_lock_cnt_nxt;
    logic [NUM_CH*DIV_W-1:0]   r_pend_div;
    logic [NUM_CH*DIV_W-1:0]   r_pend_phase;
    logic [NUM_CH*DIV_W-1:0]   w_tc_div;
    logic                      w_run;
    logic                      w_align;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_lock_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_lock_cnt <= w_lock_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_lock_cnt_nxt = r_lock_cnt;
        case (r_state)
            IDLE: begin
                w_state_nxt    = WAIT_LOCK;
                w_lock_cnt_nxt = '0;
            end
            WAIT_LOCK: begin
                if (pll_locked) begin
                    w_state_nxt    = STABLE;
                    w_lock_cnt_nxt = C_LOCK_ONE;
                end else begin
                    w_lock_cnt_nxt = '0;
                end
            end
            STABLE: begin
                if (!pll_locked) begin
                    w_state_nxt    = WAIT_LOCK;
                    w_lock_cnt_nxt = '0;
                end else if (r_lock_cnt == C_LOCK_LAST) begin
                    w_state_nxt    = ALIGN;
                end else begin
                    w_lock_cnt_nxt = r_lock_cnt + C_LOCK_ONE;
                end
            end
            ALIGN: begin
                w_state_nxt = RUN;
            end
            RUN: begin
                if (!pll_locked) begin
                    w_state_nxt = WAIT_LOCK;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign w_run   = (r_state == RUN);
    assign w_align = (r_state == ALIGN);
    assign running = w_run;
    assign sys_rst = ~w_run;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend_div   <= {NUM_CH{DIV_W'(DEF_DIV)}};
            r_pend_phase <= '0;
        end else if (cfg_load) begin
            r_pend_div   <= div_cfg;
            r_pend_phase <= phase_cfg;
        end
    end

    // A strobe landing on a terminal count feeds the reload directly.
    assign w_tc_div = cfg_load ? div_cfg : r_pend_div;

    generate
        for (genvar i = 0; i < int'(NUM_CH); i++) begin : g_chan
            amiga_clken_chan #(
                .DIV_W   (DIV_W),
                .DEF_DIV (DEF_DIV)
            ) u_chan (
                .clk          (clk),
                .rst          (rst),
                .i_run        (w_run),
                .i_align      (w_align),
                .i_pend_div   (r_pend_div[i*DIV_W +: DIV_W]),
                .i_pend_phase (r_pend_phase[i*DIV_W +: DIV_W]),
                .i_tc_div     (w_tc_div[i*DIV_W +: DIV_W]),
                .o_ce         (ce[i]),
                .o_ce_ph      (ce_ph[i])
            );
        end
    endgenerate

`ifdef AMIGA_CLKEN_STATUS_EN
    logic [7:0] r_loss_cnt;
    logic       w_lost;

    assign w_lost        = ~pll_locked & ((r_state == RUN) | (r_state == STABLE));
    assign lock_loss_cnt = r_loss_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_loss_cnt <= '0;
        end else if (w_lost && (r_loss_cnt != 8'hFF)) begin
            r_loss_cnt <= r_loss_cnt + 8'd1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_amiga_clken_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_amiga_clken_gen
// Brief    : randomized self-checking bench for amiga_clken_gen
// Revision : 1.0
// ============================================================================
module tb_amiga_clken_gen;

    localparam int NUM_CH      = 4;
    localparam int DIV_W       = 8;
    localparam int LOCK_CYCLES = 16;
    localparam int DEF_DIV     = 3;
`ifdef AMIGA_CLKEN_STATUS_EN
    localparam int VW = 2*NUM_CH + 2 + 8;
`else
    localparam int VW = 2*NUM_CH + 2;
`endif

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    pll_locked;
    logic [NUM_CH*DIV_W-1:0] div_cfg;
    logic [NUM_CH*DIV_W-1:0] phase_cfg;
    logic                    cfg_load;
    logic [NUM_CH-1:0]       ce;
    logic [NUM_CH-1:0]       ce_ph;
    logic                    sys_rst;
    logic                    running;
`ifdef AMIGA_CLKEN_STATUS_EN
    logic [7:0]              lock_loss_cnt;
`endif

    int n_vec = 0;
    int n_bad = 0;

    amiga_clken_gen #(
        .NUM_CH      (NUM_CH),
        .DIV_W       (DIV_W),
        .LOCK_CYCLES (LOCK_CYCLES),
        .DEF_DIV     (DEF_DIV)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .pll_locked    (pll_locked),
        .div_cfg       (div_cfg),
        .phase_cfg     (phase_cfg),
        .cfg_load      (cfg_load),
        .ce            (ce),
        .ce_ph         (ce_ph),
        .sys_rst       (sys_rst),
`ifdef AMIGA_CLKEN_STATUS_EN
        .lock_loss_cnt (lock_loss_cnt),
`endif
        .running       (running)
    );

    always #5 clk = ~clk;

    // Reference: lock streak length plus absolute due-times for each channel's next enable.
    bit m_idle, m_align, m_run;
    int m_streak, m_t, m_loss;
    int m_div[NUM_CH], m_next[NUM_CH], m_pdiv[NUM_CH], m_pph[NUM_CH];

    function automatic int fld(input logic [NUM_CH*DIV_W-1:0] v, input int i);
        return int'(v[i*DIV_W +: DIV_W]);
    endfunction

    task automatic set_cfg(input int i, input int d, input int p);
        div_cfg[i*DIV_W +: DIV_W]   = DIV_W'(d);
        phase_cfg[i*DIV_W +: DIV_W] = DIV_W'(p);
    endtask

    task automatic model_tick();
        int nd;
        if (rst) begin
            m_idle = 1; m_align = 0; m_run = 0; m_streak = 0; m_loss = 0; m_t = 0;
            for (int i = 0; i < NUM_CH; i++) begin
                m_div[i] = DEF_DIV; m_pdiv[i] = DEF_DIV; m_pph[i] = 0; m_next[i] = 0;
            end
        end else begin
            if (m_run) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (m_t == m_next[i]) begin
                        nd = cfg_load ? fld(div_cfg, i) : m_pdiv[i];
                        m_div[i]  = nd;
                        m_next[i] = m_t + nd + 1;
                    end
                end
                m_t++;
                if (!pll_locked) begin
                    m_run = 0; m_streak = 0;
                    if (m_loss < 255) m_loss++;
                end
            end else if (m_align) begin
                m_align = 0; m_run = 1; m_t = 0;
                for (int i = 0; i < NUM_CH; i++) begin
                    m_div[i]  = m_pdiv[i];
                    m_next[i] = (m_pph[i] < m_pdiv[i]) ? m_pph[i] : m_pdiv[i];
                end
            end else if (m_idle) begin
                m_idle = 0;
            end else if (pll_locked) begin
                m_streak++;
                if (m_streak == LOCK_CYCLES) begin
                    m_align = 1; m_streak = 0;
                end
            end else begin
                if (m_streak > 0 && m_loss < 255) m_loss++;
                m_streak = 0;
            end
            if (cfg_load) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    m_pdiv[i] = fld(div_cfg, i);
                    m_pph[i]  = fld(phase_cfg, i);
                end
            end
        end
    endtask

    function automatic logic [VW-1:0] exp_vec();
        logic [NUM_CH-1:0] e_ce, e_ph;
        e_ce = '0;
        e_ph = '0;
        if (m_run) begin
            for (int i = 0; i < NUM_CH; i++) begin
                e_ce[i] = (m_div[i] == 0) || (m_t == m_next[i]);
                e_ph[i] = (m_div[i] == 0) || ((m_next[i] - m_t) == (m_div[i] + 1) / 2);
            end
        end
`ifdef AMIGA_CLKEN_STATUS_EN
        return {!m_run, m_run, e_ce, e_ph, 8'(m_loss)};
`else
        return {!m_run, m_run, e_ce, e_ph};
`endif
    endfunction

    function automatic logic [VW-1:0] dut_vec();
`ifdef AMIGA_CLKEN_STATUS_EN
        return {sys_rst, running, ce, ce_ph, lock_loss_cnt};
`else
        return {sys_rst, running, ce, ce_ph};
`endif
    endfunction

    task automatic cycle();
        @(posedge clk);
        model_tick();
        #1;
    endtask

    task automatic test_reset();
        int n;
        rst = 1; pll_locked = 0; cfg_load = 0; div_cfg = '0; phase_cfg = '0;
        repeat (3) begin
            cycle();
            n_vec++;
            if (dut_vec() !== exp_vec() || sys_rst !== 1'b1 || running !== 1'b0 || ce !== '0) begin
                n_bad++;
                $display("FAIL reset_state got=%h exp=%h", dut_vec(), exp_vec());
            end
        end
        rst = 0;
        for (int i = 0; i < NUM_CH; i++) set_cfg(i, 3, i);
        cfg_load = 1;
        repeat (2) begin
            cycle();
            cfg_load = 0;
            n_vec++;
            if (dut_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL pre_lock got=%h exp=%h", dut_vec(), exp_vec());
            end
        end
        pll_locked = 1;
        n = 0;
        while (!running && n < 64) begin
            cycle();
            n++;
            n_vec++;
            if (dut_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL lock_seq got=%h exp=%h", dut_vec(), exp_vec());
            end
        end
        n_vec++;
        if (n !== LOCK_CYCLES + 1) begin
            n_bad++;
            $display("FAIL lock_latency got=%0d exp=%0d", n, LOCK_CYCLES + 1);
        end
    endtask

    task automatic test_default_phase();
        logic [NUM_CH-1:0] e;
        for (int k = 0; k < 16; k++) begin
            for (int i = 0; i < NUM_CH; i++) e[i] = ((k % 4) == i);
            n_vec++;
            if (dut_vec() !== exp_vec() || ce !== e) begin
                n_bad++;
                $display("FAIL phase_run k=%0d ce=%b exp_ce=%b got=%h exp=%h", k, ce, e, dut_vec(), exp_vec());
            end
            cycle();
        end
    endtask

    task automatic test_div_change();
        int got_q[$];
        int exp_q[$] = '{16, 20, 28, 36, 38, 40, 42, 44};
        for (int k = 16; k <= 44; k++) begin
            n_vec++;
            if (dut_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL div_change k=%0d got=%h exp=%h", k, dut_vec(), exp_vec());
            end
            if (ce[0]) got_q.push_back(k);
            cfg_load = 0;
            if (k == 17) begin set_cfg(0, 7, 0); cfg_load = 1; end
            if (k == 36) begin set_cfg(0, 1, 0); cfg_load = 1; end
            cycle();
        end
        cfg_load = 0;
        n_vec++;
        if (got_q != exp_q) begin
            n_bad++;
            $display("FAIL div_change_times got=%p exp=%p", got_q, exp_q);
        end
    endtask

    task automatic test_random_cfg();
        for (int k = 0; k < 300; k++) begin
            cfg_load = ($urandom_range(7, 0) == 0);
            if (cfg_load)
                for (int i = 0; i < NUM_CH; i++) set_cfg(i, $urandom_range(15, 0), $urandom_range(15, 0));
            cycle();
            n_vec++;
            if (dut_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL random_cfg k=%0d got=%h exp=%h", k, dut_vec(), exp_vec());
            end
        end
        cfg_load = 0;
    endtask

    task automatic test_lock_loss();
        int n;
        pll_locked = 0;
        cycle();
        n_vec++;
        if (dut_vec() !== exp_vec() || ce !== '0 || sys_rst !== 1'b1 || running !== 1'b0) begin
            n_bad++;
            $display("FAIL run_drop got=%h exp=%h", dut_vec(), exp_vec());
        end
`ifdef AMIGA_CLKEN_STATUS_EN
        n_vec++;
        if (lock_loss_cnt !== 8'd1) begin
            n_bad++;
            $display("FAIL loss_cnt_run got=%0d exp=1", lock_loss_cnt);
        end
`endif
        set_cfg(0, 3, 0); set_cfg(1, 2, 5); set_cfg(2, 0, 7); set_cfg(3, 5, 1);
        cfg_load = 1; pll_locked = 1;
        for (int k = 0; k < 10; k++) begin
            cycle();
            cfg_load = 0;
            n_vec++;
            if (dut_vec() !== exp_vec() || sys_rst !== 1'b1) begin
                n_bad++;
                $display("FAIL stable_count k=%0d got=%h exp=%h", k, dut_vec(), exp_vec());
            end
        end
        pll_locked = 0;
        cycle();
        n_vec++;
        if (dut_vec() !== exp_vec() || sys_rst !== 1'b1) begin
            n_bad++;
            $display("FAIL stable_drop got=%h exp=%h", dut_vec(), exp_vec());
        end
        pll_locked = 1;
        n = 0;
        while (!running && n < 64) begin
            cycle();
            n++;
            n_vec++;
            if (dut_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL relock got=%h exp=%h", dut_vec(), exp_vec());
            end
        end
        n_vec++;
        if (n !== LOCK_CYCLES + 1) begin
            n_bad++;
            $display("FAIL relock_latency got=%0d exp=%0d", n, LOCK_CYCLES + 1);
        end
        for (int k = 0; k < 12; k++) begin
            n_vec++;
            if (dut_vec() !== exp_vec() || ce[2] !== 1'b1 || ce_ph[2] !== 1'b1
                || ce[1] !== (k >= 2 && ((k - 2) % 3) == 0)) begin
                n_bad++;
                $display("FAIL div0_clamp k=%0d got=%h exp=%h", k, dut_vec(), exp_vec());
            end
            cycle();
        end
`ifdef AMIGA_CLKEN_STATUS_EN
        n_vec++;
        if (lock_loss_cnt !== 8'd2) begin
            n_bad++;
            $display("FAIL loss_cnt_stable got=%0d exp=2", lock_loss_cnt);
        end
`endif
    endtask

    task automatic test_mid_run_reset();
        int n;
        rst = 1;
        cycle();
        rst = 0;
        n_vec++;
        if (dut_vec() !== exp_vec() || sys_rst !== 1'b1 || running !== 1'b0 || ce !== '0) begin
            n_bad++;
            $display("FAIL mid_run_rst got=%h exp=%h", dut_vec(), exp_vec());
        end
        n = 0;
        while (!running && n < 64) begin
            cycle();
            n++;
            n_vec++;
            if (dut_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL post_rst_lock got=%h exp=%h", dut_vec(), exp_vec());
            end
        end
        n_vec++;
        if (n !== LOCK_CYCLES + 2) begin
            n_bad++;
            $display("FAIL post_rst_latency got=%0d exp=%0d", n, LOCK_CYCLES + 2);
        end
        for (int k = 0; k < 8; k++) begin
            n_vec++;
            if (dut_vec() !== exp_vec() || ce !== (((k % 4) == 0) ? 4'hF : 4'h0)) begin
                n_bad++;
                $display("FAIL default_div k=%0d ce=%b got=%h exp=%h", k, ce, dut_vec(), exp_vec());
            end
            cycle();
        end
    endtask

    task automatic test_random_lock();
        for (int k = 0; k < 600; k++) begin
            pll_locked = ($urandom_range(39, 0) != 0);
            cfg_load   = ($urandom_range(5, 0) == 0);
            if (cfg_load)
                for (int i = 0; i < NUM_CH; i++) set_cfg(i, $urandom_range(15, 0), $urandom_range(15, 0));
            cycle();
            n_vec++;
            if (dut_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL random_lock k=%0d got=%h exp=%h", k, dut_vec(), exp_vec());
            end
        end
        cfg_load = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_default_phase();
        test_div_change();
        test_random_cfg();
        test_lock_loss();
        test_mid_run_reset();
        test_random_lock();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
